dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller placed between the pipeline's MEM stage and the off-chip data memory.
- It serves MEM-stage loads and stores on a hit with no added latency.
- On a miss it stalls the pipeline while it writes back the dirty victim line and refills the line using a 256-bit memory handshake.

---
 rtl/dcache_ctrl_if.sv | 23 ++
 rtl/dcache_ctrl.sv | 74 +++++++
 tb/tb_dcache_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: MEM-stage request/response and 256-bit memory line handshake of the data cache.
interface dcache_ctrl_if;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  modport slave (
    input  req, we, addr, wdata, mem_rdata, mem_ack,
    output rdata, stall, mem_enable, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req, we, addr, wdata, mem_rdata, mem_ack,
    input  rdata, stall, mem_enable, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with a single-line memory handshake.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = 5,
  parameter int OFFSET_W  = 5,
  parameter int TAG_W     = 32 - INDEX_W - OFFSET_W
) (
  input logic          clk,
  input logic          rst_n,
  dcache_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t               state;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [255:0]         lines [NUM_LINES];
  logic [TAG_W-1:0]     tag;
  logic [INDEX_W-1:0]   index;
  logic [2:0]           word;
  logic                 hit, miss, victim_dirty;
  assign tag          = bus.addr[31 -: TAG_W];
  assign index        = bus.addr[OFFSET_W +: INDEX_W];
  assign word         = bus.addr[4:2];
  assign hit          = state == IDLE && bus.req && valid[index] && tags[index] == tag;
  assign miss         = state == IDLE && bus.req && !hit;
  assign victim_dirty = valid[index] && dirty[index];
  assign bus.rdata    = hit && !bus.we ? lines[index][{word, 5'b0} +: 32] : 32'b0;
  // stall is forced low while reset is asserted even if a request is held
  assign bus.stall    = rst_n && (state != IDLE || miss);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      valid          <= '0;
      dirty          <= '0;
      bus.mem_enable <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE:
          if (miss) begin
            state          <= victim_dirty ? WRITEBACK : ALLOCATE;
            bus.mem_enable <= 1'b1;
            bus.mem_write  <= victim_dirty;
            bus.mem_addr   <= {victim_dirty ? tags[index] : tag, index, {OFFSET_W{1'b0}}};
            bus.mem_wdata  <= victim_dirty ? lines[index] : '0;
          end else if (hit && bus.we) dirty[index] <= 1'b1;
        WRITEBACK:
          if (bus.mem_ack) begin
            state         <= ALLOCATE;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= {tag, index, {OFFSET_W{1'b0}}};
            bus.mem_wdata <= '0;
          end
        ALLOCATE:
          if (bus.mem_ack) begin
            state          <= REFILL;
            valid[index]   <= 1'b1;
            dirty[index]   <= 1'b0;
            bus.mem_enable <= 1'b0;
            bus.mem_addr   <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk) begin
    if (hit && bus.we) lines[index][{word, 5'b0} +: 32] <= bus.wdata;
    if (state == ALLOCATE && bus.mem_ack) begin
      lines[index] <= bus.mem_rdata;
      tags[index]  <= tag;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed accesses with a scoreboard of expected load data and memory transactions.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  dcache_ctrl_if bus();
  dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_tx_t;
  mem_tx_t      exp_mem[$];
  logic [31:0]  exp_rd[$];
  logic [255:0] mem [logic [26:0]];
  int tests = 0;
  int fails = 0;
  int lat = 3;
  int mcnt = 0;
  logic         prev_en = 1'b0, prev_ack = 1'b0, prev_wr = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [255:0] prev_data = '0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory model: acks in the lat-th cycle a request is presented
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_enable) begin
        mcnt++;
        if (mcnt >= lat) begin
          mcnt = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_write) mem[bus.mem_addr[31:5]] = bus.mem_wdata;
          else bus.mem_rdata = mem.exists(bus.mem_addr[31:5]) ? mem[bus.mem_addr[31:5]] : '0;
        end
      end else mcnt = 0;
    end
  end
  always @(negedge clk) begin
    if (rst_n && bus.req && !bus.stall && !bus.we) begin
      if (exp_rd.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rdata: unexpected load completion, got %h", bus.rdata);
      end else chk("rdata", bus.rdata, exp_rd.pop_front());
    end else chk("rdata_zero", bus.rdata, 0);
    if (bus.mem_enable && bus.mem_ack) begin
      if (exp_mem.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mem_tx: unexpected transfer at %h write %b", bus.mem_addr, bus.mem_write);
      end else begin
        mem_tx_t e;
        e = exp_mem.pop_front();
        chk("mem_write", bus.mem_write, e.wr);
        chk("mem_addr", bus.mem_addr, e.addr);
        if (e.wr) chk("mem_data", bus.mem_wdata, e.data);
      end
    end
    if (bus.mem_enable && prev_en && !prev_ack) begin
      chk("hold_write", bus.mem_write, prev_wr);
      chk("hold_addr", bus.mem_addr, prev_addr);
      chk("hold_data", bus.mem_wdata, prev_data);
    end
    if (!bus.mem_enable) begin
      chk("idle_write", bus.mem_write, 0);
      chk("idle_addr", bus.mem_addr, 0);
      chk("idle_data", bus.mem_wdata, 0);
    end
    prev_en   <= bus.mem_enable;
    prev_ack  <= bus.mem_ack;
    prev_wr   <= bus.mem_write;
    prev_addr <= bus.mem_addr;
    prev_data <= bus.mem_wdata;
  end
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int exp_stall,
                        input string name);
    int n = 0;
    @(posedge clk);
    #2;
    bus.req = 1'b1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    @(negedge clk);
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_stall);
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    bus.we = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    int n;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    mem[27'h020] = 256'hDEADBEEF << 32;
    mem[27'h120] = 256'hCAFEF00D;
    mem[27'h001] = 256'h11111111 << 32;
    mem[27'h021] = 256'h0BADCAFE;
    mem[27'h200] = 256'h600DF00D;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_enable", bus.mem_enable, 0);
    chk("rst_rdata", bus.rdata, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // clean load miss
    exp_mem.push_back('{1'b0, 32'h0000_0400, '0});
    exp_rd.push_back(32'hDEADBEEF);
    access(1'b0, 32'h0000_0404, 32'h0, 5, "t1_stall");
    // store hit then load hits
    access(1'b1, 32'h0000_0408, 32'h12345678, 0, "t2_store_stall");
    exp_rd.push_back(32'h12345678);
    access(1'b0, 32'h0000_0408, 32'h0, 0, "t2_load_stall");
    exp_rd.push_back(32'hDEADBEEF);
    access(1'b0, 32'h0000_0404, 32'h0, 0, "t2_other_word_stall");
    // dirty conflict miss on index 0
    exp_mem.push_back('{1'b1, 32'h0000_0400, (256'hDEADBEEF << 32) | (256'h12345678 << 64)});
    exp_mem.push_back('{1'b0, 32'h0000_2400, '0});
    exp_rd.push_back(32'hCAFEF00D);
    access(1'b0, 32'h0000_2400, 32'h0, 8, "t3_stall");
    // store miss to a clean line merges into the refilled data
    exp_mem.push_back('{1'b0, 32'h0000_0020, '0});
    access(1'b1, 32'h0000_0020, 32'hA5A5A5A5, 5, "t4_stall");
    exp_rd.push_back(32'hA5A5A5A5);
    access(1'b0, 32'h0000_0020, 32'h0, 0, "t4_word0_stall");
    exp_rd.push_back(32'h11111111);
    access(1'b0, 32'h0000_0024, 32'h0, 0, "t4_word1_stall");
    // slow memory: eviction of the merged dirty line, handshake held for 20 cycles
    lat = 20;
    exp_mem.push_back('{1'b1, 32'h0000_0020, 256'hA5A5A5A5 | (256'h11111111 << 32)});
    exp_mem.push_back('{1'b0, 32'h0000_0420, '0});
    exp_rd.push_back(32'h0BADCAFE);
    access(1'b0, 32'h0000_0420, 32'h0, 42, "t6_stall");
    // reset in the middle of an ALLOCATE
    lat = 10;
    @(posedge clk);
    #2;
    bus.req = 1'b1;
    bus.we = 1'b0;
    bus.addr = 32'h0000_4000;
    n = 0;
    @(negedge clk);
    while (!bus.mem_enable && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t5_alloc_enable", bus.mem_enable, 1);
    chk("t5_alloc_write", bus.mem_write, 0);
    chk("t5_alloc_addr", bus.mem_addr, 32'h0000_4000);
    @(negedge clk);
    chk("t5_stall_before", bus.stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_enable", bus.mem_enable, 0);
    chk("t5_rst_stall", bus.stall, 0);
    chk("t5_rst_rdata", bus.rdata, 0);
    bus.req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    lat = 3;
    exp_mem.push_back('{1'b0, 32'h0000_4000, '0});
    exp_rd.push_back(32'h600DF00D);
    access(1'b0, 32'h0000_4000, 32'h0, 5, "t5_remiss_stall");
    exp_mem.push_back('{1'b0, 32'h0000_0020, '0});
    exp_rd.push_back(32'hA5A5A5A5);
    access(1'b0, 32'h0000_0020, 32'h0, 5, "t5_valid_cleared_stall");
    repeat (2) @(posedge clk);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
